// File: rtl/axilite_pkg.sv
// Shared types and constants for the AXI4-Lite register arbiter.
package axilite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/axilite_reg_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant only advances when enabled with a live request.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       last_grant
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        last_d = last_q;
        if (en && (req != 2'b00))
            last_d = gnt[1];
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

    assign last_grant = last_q;

endmodule

// File: rtl/axilite_reg_arbiter.sv
// Single-outstanding AXI4-Lite master shared by two command requesters.
module axilite_reg_arbiter
    import axilite_pkg::*;
#(
    parameter int         ADDR_W = 20,
    parameter logic [2:0] PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*STRB_W-1:0]   req_wstrb,
    output logic [1:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_resp,
    output logic                  busy,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [STRB_W-1:0]     m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [2:0]            m_arprot,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp
);

    state_e              state_q, state_d;
    logic [1:0]          req_ready_q, req_ready_d;
    logic                cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [STRB_W-1:0]   cmd_wstrb_q, cmd_wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [1:0]          resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]          resp_resp_q, resp_resp_d;
    logic                busy_q, busy_d;

    logic       arb_en;
    logic [1:0] gnt;
    logic       last_grant;
    logic       sel;

    // A pending req_ready marks the grant cycle; no second grant may be issued in it.
    assign arb_en = (state_q == ST_IDLE) && (req_ready_q == 2'b00);
    assign sel    = gnt[1];

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .en         (arb_en),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = 2'b00;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_wstrb_d  = cmd_wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = 2'b00;
        resp_rdata_d = resp_rdata_q;
        resp_resp_d  = resp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (req_ready_q != 2'b00) begin
                    if (cmd_write_q) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end else if (gnt != 2'b00) begin
                    req_ready_d = gnt;
                    cmd_write_d = sel ? req_write[1] : req_write[0];
                    cmd_addr_d  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    cmd_wdata_d = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    cmd_wstrb_d = sel ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
                end
            end
            ST_WADDR: begin
                // AW and W retire independently; B opens once both are gone.
                awvalid_d = awvalid_q & ~m_awready;
                wvalid_d  = wvalid_q & ~m_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_bvalid) begin
                    bready_d     = 1'b0;
                    resp_rdata_d = '0;
                    resp_resp_d  = m_bresp;
                    resp_valid_d = last_grant ? 2'b10 : 2'b01;
                    state_d      = ST_RESP;
                end
            end
            ST_RADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_rvalid) begin
                    rready_d     = 1'b0;
                    resp_rdata_d = m_rdata;
                    resp_resp_d  = m_rresp;
                    resp_valid_d = last_grant ? 2'b10 : 2'b01;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 2'b00;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_wstrb_q  <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_resp_q  <= RESP_OKAY;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_wstrb_q  <= cmd_wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_resp_q  <= resp_resp_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_resp  = resp_resp_q;
    assign busy       = busy_q;
    assign m_awvalid  = awvalid_q;
    assign m_awaddr   = cmd_addr_q;
    assign m_awprot   = PROT;
    assign m_wvalid   = wvalid_q;
    assign m_wdata    = cmd_wdata_q;
    assign m_wstrb    = cmd_wstrb_q;
    assign m_bready   = bready_q;
    assign m_arvalid  = arvalid_q;
    assign m_araddr   = cmd_addr_q;
    assign m_arprot   = PROT;
    assign m_rready   = rready_q;

endmodule

// File: tb/tb_axilite_reg_arbiter.sv
// Scoreboard bench: two requester drivers, a wait-state AXI-Lite slave, and a negedge monitor.
module tb_axilite_reg_arbiter;
    import axilite_pkg::*;

    localparam int         AW   = 20;
    localparam logic [2:0] PROT = 3'b000;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
    } cmd_t;

    typedef struct packed {
        logic        idx;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    logic clk, rst;
    logic [1:0] req_valid, req_ready, req_write, resp_valid, resp_resp;
    logic [2*AW-1:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [31:0] resp_rdata;
    logic busy;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0] m_awprot, m_arprot;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0] m_wstrb;
    logic [1:0] m_bresp, m_rresp;

    int n_tests = 0;
    int n_fail  = 0;

    // slave configuration
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic        rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = 32'h0;

    // scoreboard and monitor state
    exp_t          sb[$];
    logic [AW-1:0] exp_aw[$];
    logic [35:0]   exp_w[$];
    logic [AW-1:0] exp_ar[$];
    int            grant_log[$];
    int cyc = 0, rdy_cyc = 0, last_lat = 0, hs_cyc = 0, ar_run = 0, ar_hold = 0;

    cmd_t rc[2];

    axilite_reg_arbiter #(.ADDR_W(AW), .PROT(PROT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_resp(resp_resp), .busy(busy),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {12'h000, a};
    endfunction

    // requester drivers: valid held until req_ready, next command follows back to back
    for (genvar g = 0; g < 2; g++) begin : g_req
        logic v;
        cmd_t c;
        cmd_t q[$];
        initial begin
            int n;
            v = 1'b0;
            c = '0;
            forever begin
                @(posedge clk); #1;
                while (q.size() > 0) begin
                    c = q.pop_front();
                    v = 1'b1;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!req_ready[g] && n < 2000);
                    if (!req_ready[g]) chk("req_wait", req_ready[g], 1'b1);
                    @(posedge clk); #1;
                end
                v = 1'b0;
            end
        end
    end

    assign rc[0]     = g_req[0].c;
    assign rc[1]     = g_req[1].c;
    assign req_valid = {g_req[1].v, g_req[0].v};
    assign req_write = {rc[1].w, rc[0].w};
    assign req_addr  = {rc[1].a, rc[0].a};
    assign req_wdata = {rc[1].d, rc[0].d};
    assign req_wstrb = {rc[1].s, rc[0].s};

    // slave: each ready/valid appears after the configured number of wait cycles
    initial begin
        int awc, wc, bc, arc, rcnt;
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
        {awc, wc, bc, arc, rcnt} = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
                m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
                awc = 0; wc = 0; bc = 0; arc = 0; rcnt = 0;
            end else begin
                if (m_awvalid) begin m_awready = (awc >= aw_wait); awc++; end
                else begin m_awready = 1'b0; awc = 0; end
                if (m_wvalid) begin m_wready = (wc >= w_wait); wc++; end
                else begin m_wready = 1'b0; wc = 0; end
                if (m_arvalid) begin m_arready = (arc >= ar_wait); arc++; end
                else begin m_arready = 1'b0; arc = 0; end
                if (m_bready) begin m_bvalid = (bc >= b_wait); m_bresp = bresp_cfg; bc++; end
                else begin m_bvalid = 1'b0; bc = 0; end
                if (m_rready) begin
                    m_rvalid = (rcnt >= r_wait);
                    m_rdata  = rd_fixed_en ? rd_fixed : rd_fn(m_araddr);
                    m_rresp  = rresp_cfg;
                    rcnt++;
                end else begin
                    m_rvalid = 1'b0; m_rdata = '0; rcnt = 0;
                end
            end
        end
    end

    // monitor: expectations pushed on grant, popped on handshakes and responses
    initial begin
        logic aw_prev, w_prev, ar_prev, b_prev, r_prev, aw_done, w_done;
        logic idx;
        cmd_t cm;
        exp_t e;
        {aw_prev, w_prev, ar_prev, b_prev, r_prev, aw_done, w_done} = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                {aw_prev, w_prev, ar_prev, b_prev, r_prev, aw_done, w_done} = '0;
                ar_run = 0;
                continue;
            end
            if (aw_prev) chk("aw_drop", m_awvalid, 1'b0);
            if (w_prev)  chk("w_drop",  m_wvalid,  1'b0);
            if (ar_prev) chk("ar_drop", m_arvalid, 1'b0);

            if (req_ready != 2'b00) begin
                idx = req_ready[1];
                chk("rdy_idle", {busy, req_ready[0] & req_ready[1]}, 2'b00);
                grant_log.push_back(int'(idx));
                rdy_cyc = cyc;
                cm = rc[idx];
                e.idx = idx;
                if (cm.w) begin
                    e.rdata = '0; e.resp = bresp_cfg;
                    exp_aw.push_back(cm.a);
                    exp_w.push_back({cm.d, cm.s});
                end else begin
                    e.rdata = rd_fixed_en ? rd_fixed : rd_fn(cm.a);
                    e.resp  = rresp_cfg;
                    exp_ar.push_back(cm.a);
                end
                sb.push_back(e);
            end

            if (m_awvalid && m_awready) begin
                if (exp_aw.size() > 0) chk("awaddr", m_awaddr, exp_aw.pop_front());
                else chk("aw_extra", m_awvalid, 1'b0);
                aw_done = 1'b1; hs_cyc = cyc;
            end
            if (m_wvalid && m_wready) begin
                if (exp_w.size() > 0) chk("wdata_strb", {m_wdata, m_wstrb}, exp_w.pop_front());
                else chk("w_extra", m_wvalid, 1'b0);
                w_done = 1'b1; hs_cyc = cyc;
            end
            if (m_arvalid) ar_run++;
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() > 0) chk("araddr", m_araddr, exp_ar.pop_front());
                else chk("ar_extra", m_arvalid, 1'b0);
                ar_hold = ar_run;
            end
            if (!m_arvalid) ar_run = 0;

            if (m_bready && !b_prev) begin
                chk("bready_order", {aw_done, w_done}, 2'b11);
                chk("bready_time", cyc - hs_cyc, 1);
                aw_done = 1'b0; w_done = 1'b0;
            end

            if (r_prev) chk("resp_pulse", resp_valid, 2'b00);
            if (resp_valid != 2'b00) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_valid", resp_valid, e.idx ? 2'b10 : 2'b01);
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_resp",  resp_resp,  e.resp);
                    last_lat = cyc - rdy_cyc;
                end else begin
                    chk("resp_extra", resp_valid, 2'b00);
                end
            end

            aw_prev = m_awvalid && m_awready;
            w_prev  = m_wvalid && m_wready;
            ar_prev = m_arvalid && m_arready;
            b_prev  = m_bready;
            r_prev  = (resp_valid != 2'b00);
        end
    end

    task automatic issue(input int r, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cmd_t c;
        c = '{w: w, a: a, d: d, s: s};
        if (r == 0) g_req[0].q.push_back(c);
        else        g_req[1].q.push_back(c);
    endtask

    task automatic wait_idle();
        int pend;
        pend = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            pend = sb.size() + g_req[0].q.size() + g_req[1].q.size()
                 + int'(g_req[0].v) + int'(g_req[1].v) + int'(busy) + int'(req_ready != 2'b00);
            if (pend == 0) return;
        end
        chk("idle_timeout", pend, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"}, {req_ready, resp_valid, busy, m_awvalid, m_wvalid, m_bready,
                            m_arvalid, m_rready}, '0);
        chk({tag, "_rdata"}, resp_rdata, '0);
        chk({tag, "_resp"},  resp_resp,  '0);
        chk({tag, "_addr"},  {m_awaddr, m_araddr, m_wdata, m_wstrb}, '0);
        chk({tag, "_prot"},  {m_awprot, m_arprot}, {PROT, PROT});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        #12;
        chk_reset_state("rst0");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // zero-wait write from requester 0
        issue(0, 1'b1, 20'h00004, 32'hA5A5_0001, 4'hF);
        wait_idle();
        chk("wr_lat", last_lat, 3);

        // read from requester 1 with two wait cycles on AR and R
        ar_wait = 2; r_wait = 2; rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678;
        issue(1, 1'b0, 20'h00010, 32'h0, 4'h0);
        wait_idle();
        chk("ar_hold", ar_hold, 3);
        ar_wait = 0; r_wait = 0; rd_fixed_en = 1'b0;

        // both requesters continuously valid: grants must alternate starting at 0
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            issue(0, 1'b1, 20'h00100 + 20'(k * 4), 32'hD000_0000 + k, 4'hF);
            issue(1, 1'b0, 20'h00200 + 20'(k * 4), 32'h0, 4'h0);
        end
        wait_idle();
        chk("alt_cnt", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++)
            chk("alt_order", grant_log[k], k % 2);

        // AW/W handshake ordering: W first, AW first, same cycle
        aw_wait = 2; w_wait = 0;
        issue(0, 1'b1, 20'h00020, 32'h0BAD_F00D, 4'h3);
        wait_idle();
        aw_wait = 0; w_wait = 2;
        issue(1, 1'b1, 20'h00024, 32'h5555_AAAA, 4'hC);
        wait_idle();
        aw_wait = 1; w_wait = 1;
        issue(0, 1'b1, 20'h00028, 32'h0F0F_F0F0, 4'h9);
        wait_idle();
        aw_wait = 0; w_wait = 0;

        // error responses pass through
        bresp_cfg = RESP_SLVERR;
        issue(1, 1'b1, 20'h00030, 32'hDEAD_BEEF, 4'hF);
        wait_idle();
        chk("err_wr_busy", busy, 1'b0);
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_DECERR;
        issue(0, 1'b0, 20'h00034, 32'h0, 4'h0);
        wait_idle();
        chk("rd_lat", last_lat, 3);
        chk("err_rd_busy", busy, 1'b0);
        rresp_cfg = RESP_OKAY;

        // asynchronous reset while waiting in WRESP
        b_wait = 6;
        issue(0, 1'b1, 20'h00040, 32'h1111_2222, 4'hF);
        n = 0;
        while (!m_bready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wresp", m_bready, 1'b1);
        #2 rst = 1'b1;
        #1 chk_reset_state("rst1");
        sb.delete(); exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        b_wait = 0;
        grant_log.delete();
        issue(0, 1'b1, 20'h00044, 32'h3333_4444, 4'hF);
        issue(1, 1'b0, 20'h00048, 32'h0, 4'h0);
        wait_idle();
        chk("post_rst_cnt", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("post_rst_tie", grant_log[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
